sim_mem_system: RTL

Simulation-side memory subsystem for the CPU testbench. It is a single-master bus slave with a word RAM, a machine timer/software-interrupt block and a tohost mailbox.
Response latency is configurable, and address-range and alignment checking produce error responses.
It replaces the plain RAM on the CPU memory port. It also drives the CPU interrupt inputs xint_mtip and xint_msip.

---
 rtl/sim_mem_system.sv | 117 +++++++++++
 1 files changed

// File: rtl/sim_mem_system.sv
// sim_mem_system: simulation bus slave with word RAM, machine timer/msip and tohost mailbox
module sim_mem_system #(
    parameter int          ADDR_WIDTH = 24,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter logic [31:0] IO_BASE    = 32'h0200_0000,
    parameter int          LATENCY    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wsel,
    input  logic        mem_valid,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_error,
    output logic        xint_mtip,
    output logic        xint_msip,
    output logic [31:0] tohost_data,
    output logic        tohost_valid
);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
    logic [1:0] state;
    logic [3:0] cnt, lat_wsel, ws;
    logic [31:0] lat_addr, lat_wdata, a, wd, off_b, io_rd;
    logic [31:0] ram [2**(ADDR_WIDTH-2)];
    logic [63:0] mtime, mtimecmp, mtime_n, mtimecmp_n;
    logic [ADDR_WIDTH-3:0] idx;
    logic [2:0] off;
    logic go, is_ram, is_io, err, wr, io_wr;

    function automatic logic [31:0] merge(input logic [31:0] old, d, input logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    // With zero latency the response is decided in the accepting cycle, before the latch is loaded
    assign a      = state == IDLE ? mem_address : lat_addr;
    assign wd     = state == IDLE ? mem_wdata : lat_wdata;
    assign ws     = state == IDLE ? mem_wsel : lat_wsel;
    assign go     = (state == IDLE && mem_valid && LATENCY == 0) || (state == WAIT && cnt == 4'd0);
    assign off_b  = a - IO_BASE;
    assign is_io  = off_b < 32'd32;
    assign off    = off_b[4:2];
    assign is_ram = ((a ^ BASE_ADDR) >> ADDR_WIDTH) == 32'd0;
    assign err    = a[1:0] != 2'd0 || !(is_ram || is_io);
    assign wr     = |ws;
    assign io_wr  = go && !err && is_io && wr;
    assign idx    = a[ADDR_WIDTH-1:2];

    assign mtime_n = io_wr && off == 3'd0 ? {mtime[63:32], merge(mtime[31:0], wd, ws)} :
                     io_wr && off == 3'd1 ? {merge(mtime[63:32], wd, ws), mtime[31:0]} : mtime + 64'd1;
    assign mtimecmp_n = io_wr && off == 3'd2 ? {mtimecmp[63:32], merge(mtimecmp[31:0], wd, ws)} :
                        io_wr && off == 3'd3 ? {merge(mtimecmp[63:32], wd, ws), mtimecmp[31:0]} : mtimecmp;

    always_comb begin
        io_rd = 32'd0;
        case (off)
            3'd0: io_rd = mtime[31:0];
            3'd1: io_rd = mtime[63:32];
            3'd2: io_rd = mtimecmp[31:0];
            3'd3: io_rd = mtimecmp[63:32];
            3'd4: io_rd = {31'd0, xint_msip};
            3'd5: io_rd = tohost_data;
            default: io_rd = 32'd0;
        endcase
    end

    always_ff @(posedge clk)
        if (!rst && go && !err && is_ram && wr) ram[idx] <= merge(ram[idx], wd, ws);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            lat_wsel     <= 4'd0;
            mem_rdata    <= 32'd0;
            mem_ready    <= 1'b0;
            mem_error    <= 1'b0;
            mtime        <= 64'd0;
            mtimecmp     <= '1;
            xint_mtip    <= 1'b0;
            xint_msip    <= 1'b0;
            tohost_data  <= 32'd0;
            tohost_valid <= 1'b0;
        end else begin
            mem_ready <= go && !err;
            mem_error <= go && err;
            mem_rdata <= go && !err && !wr ? (is_ram ? ram[idx] : io_rd) : 32'd0;
            mtime     <= mtime_n;
            mtimecmp  <= mtimecmp_n;
            xint_mtip <= mtime >= mtimecmp;
            if (io_wr && off == 3'd4 && ws[0]) xint_msip <= wd[0];
            if (io_wr && off == 3'd5) begin
                tohost_data  <= merge(tohost_data, wd, ws);
                tohost_valid <= 1'b1;
            end
            case (state)
                IDLE: if (mem_valid) begin
                    lat_addr  <= mem_address;
                    lat_wdata <= mem_wdata;
                    lat_wsel  <= mem_wsel;
                    state     <= LATENCY == 0 ? RESP : WAIT;
                    cnt       <= 4'(LATENCY - 1);
                end
                WAIT: begin
                    state <= cnt == 4'd0 ? RESP : WAIT;
                    cnt   <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
